// File: rtl/rv_pkg.sv
// Shared RV64 pipeline definitions.
// Load/store funct3 encodings, access sizes and MEM FSM states.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, load extraction/extension
// and natural-alignment check.
module mem_align
  import rv_pkg::*;
(
  input  logic [2:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [63:0] load_data,
  output logic        aligned
);

  size_e       sz;
  logic        uns;
  logic [5:0]  bit_off;
  logic [63:0] sh;
  logic [7:0]  mask;

  assign sz      = size_e'(funct3[1:0]);
  assign uns     = funct3[2];
  assign bit_off = {lane, 3'b000};
  assign wdata   = store_data << bit_off;
  assign sh      = rdata >> bit_off;
  assign wstrb   = mask << lane;

  // LDU (111) falls into SZ_D and is returned unextended
  always_comb begin
    mask      = 8'h00;
    aligned   = 1'b0;
    load_data = 64'd0;
    unique case (sz)
      SZ_B: begin
        mask      = 8'h01;
        aligned   = 1'b1;
        load_data = uns ? {56'd0, sh[7:0]}
                        : {{56{sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        mask      = 8'h03;
        aligned   = (lane[0] == 1'b0);
        load_data = uns ? {48'd0, sh[15:0]}
                        : {{48{sh[15]}}, sh[15:0]};
      end
      SZ_W: begin
        mask      = 8'h0F;
        aligned   = (lane[1:0] == 2'b00);
        load_data = uns ? {32'd0, sh[31:0]}
                        : {{32{sh[31]}}, sh[31:0]};
      end
      SZ_D: begin
        mask      = 8'hFF;
        aligned   = (lane == 3'b000);
        load_data = sh;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 MEM stage: data-memory handshake, stall/timeout FSM
// and MEM/WB pipeline register.
module mem_stage
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] reg_data2_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [63:0] dmem_rdata,
  output logic        stall_out,
  output logic [63:0] wb_data_out,
  output logic [4:0]  wb_rd_out,
  output logic        wb_RegWrite_out,
  output logic        misalign_err_out,
  output logic        bus_err_out
);

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  mem_state_e  state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        acc, we;
  logic        aligned;
  logic [7:0]  strb;
  logic [63:0] load_data;
  logic        req_c, stall_c;
  logic        done, misalign, timeout;

  assign acc = MemRead_in | MemWrite_in;
  assign we  = MemWrite_in & ~MemRead_in;

  mem_align u_align (
    .lane       (alu_result_in[2:0]),
    .funct3     (funct3_in),
    .store_data (reg_data2_in),
    .rdata      (dmem_rdata),
    .wdata      (dmem_wdata),
    .wstrb      (strb),
    .load_data  (load_data),
    .aligned    (aligned)
  );

  assign dmem_addr  = {alu_result_in[63:3], 3'b000};
  assign dmem_we    = we;
  assign dmem_wstrb = we ? strb : 8'h00;
  // Gating by reset drops the request asynchronously mid-WAIT
  assign dmem_req   = req_c & ~reset;
  assign stall_out  = stall_c & ~reset;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    done     = 1'b0;
    misalign = 1'b0;
    timeout  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (acc && aligned) begin
          req_c = 1'b1;
          if (dmem_ready) begin
            done = 1'b1;
          end else begin
            stall_c  = 1'b1;
            state_nx = S_WAIT;
            cnt_nx   = 16'd1;
          end
        end else if (acc) begin
          misalign = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      S_WAIT: begin
        req_c = 1'b1;
        if (dmem_ready) begin
          done     = 1'b1;
          state_nx = S_IDLE;
          cnt_nx   = 16'd0;
        end else if (cnt == TMO) begin
          req_c    = 1'b0;
          timeout  = 1'b1;
          state_nx = S_IDLE;
          cnt_nx   = 16'd0;
        end else begin
          stall_c = 1'b1;
          cnt_nx  = cnt + 16'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data_out      <= 64'd0;
      wb_rd_out        <= 5'd0;
      wb_RegWrite_out  <= 1'b0;
      misalign_err_out <= 1'b0;
      bus_err_out      <= 1'b0;
    end else begin
      misalign_err_out <= misalign;
      bus_err_out      <= timeout;
      if (done) begin
        wb_data_out     <= MemtoReg_in ? load_data
                                       : alu_result_in;
        wb_rd_out       <= rd_in;
        wb_RegWrite_out <= RegWrite_in;
      end else begin
        wb_RegWrite_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage.
// Hand-computed vectors for ALU, loads, stores, errors, reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] alu_result_in;
  logic [63:0] reg_data2_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        RegWrite_in, MemtoReg_in;
  logic        MemRead_in, MemWrite_in;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;
  logic        stall_out;
  logic [63:0] wb_data_out;
  logic [4:0]  wb_rd_out;
  logic        wb_RegWrite_out;
  logic        misalign_err_out, bus_err_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .alu_result_in    (alu_result_in),
    .reg_data2_in     (reg_data2_in),
    .rd_in            (rd_in),
    .funct3_in        (funct3_in),
    .RegWrite_in      (RegWrite_in),
    .MemtoReg_in      (MemtoReg_in),
    .MemRead_in       (MemRead_in),
    .MemWrite_in      (MemWrite_in),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_wstrb       (dmem_wstrb),
    .dmem_ready       (dmem_ready),
    .dmem_rdata       (dmem_rdata),
    .stall_out        (stall_out),
    .wb_data_out      (wb_data_out),
    .wb_rd_out        (wb_rd_out),
    .wb_RegWrite_out  (wb_RegWrite_out),
    .misalign_err_out (misalign_err_out),
    .bus_err_out      (bus_err_out)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a,
                       input logic [63:0] d2,
                       input logic [4:0]  rd,
                       input logic [2:0]  f3,
                       input logic rw, input logic m2r,
                       input logic mr, input logic mw);
    alu_result_in = a;
    reg_data2_in  = d2;
    rd_in         = rd;
    funct3_in     = f3;
    RegWrite_in   = rw;
    MemtoReg_in   = m2r;
    MemRead_in    = mr;
    MemWrite_in   = mw;
  endtask

  task automatic idle();
    drive(64'd0, 64'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lb_wait(input logic [2:0] f3,
                         input logic [63:0] exp,
                         input logic [63:0] prev);
    drive(64'h105, 64'd0, 5'd9, f3, 1'b1, 1'b1, 1'b1, 1'b0);
    dmem_ready = 1'b0;
    dmem_rdata = 64'h0000_F600_0000_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lb_stall", stall_out, 1);
      check("lb_req", dmem_req, 1);
      tick();
      check("lb_bubble", wb_RegWrite_out, 0);
      check("lb_hold", wb_data_out, prev);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("lb_nostall", stall_out, 0);
    tick();
    check("lb_data", wb_data_out, exp);
    check("lb_rd", wb_rd_out, 9);
    check("lb_we", wb_RegWrite_out, 1);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    dmem_rdata = 64'd0;
    idle();
    // asserted request is suppressed during reset
    drive(64'h100, 64'd0, 5'd1, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0);
    #12;
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall_out, 0);
    check("rst_wb_data", wb_data_out, 0);
    check("rst_wb_rd", wb_rd_out, 0);
    check("rst_wb_we", wb_RegWrite_out, 0);
    check("rst_errs", {misalign_err_out, bus_err_out}, 0);
    idle();
    @(negedge clk);
    reset = 1'b0;

    // ALU op
    drive(64'h1234, 64'd0, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("alu_req", dmem_req, 0);
    check("alu_stall", stall_out, 0);
    tick();
    check("alu_data", wb_data_out, 64'h1234);
    check("alu_rd", wb_rd_out, 5);
    check("alu_we", wb_RegWrite_out, 1);

    // LD zero wait
    drive(64'h100, 64'd0, 5'd7, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0);
    dmem_ready = 1'b1;
    dmem_rdata = 64'h8877665544332211;
    @(negedge clk);
    check("ld_req", dmem_req, 1);
    check("ld_we", dmem_we, 0);
    check("ld_strb", dmem_wstrb, 0);
    check("ld_addr", dmem_addr, 64'h100);
    check("ld_stall", stall_out, 0);
    tick();
    check("ld_data", wb_data_out, 64'h8877665544332211);
    check("ld_rd", wb_rd_out, 7);
    idle();

    lb_wait(3'b000, 64'hFFFF_FFFF_FFFF_FFF6,
            64'h8877665544332211);
    lb_wait(3'b100, 64'h0000_0000_0000_00F6,
            64'hFFFF_FFFF_FFFF_FFF6);

    // SH
    drive(64'h106, 64'hABCD, 5'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    dmem_ready = 1'b1;
    @(negedge clk);
    check("sh_req", dmem_req, 1);
    check("sh_we", dmem_we, 1);
    check("sh_strb", dmem_wstrb, 8'hC0);
    check("sh_wdata", dmem_wdata, 64'hABCD_0000_0000_0000);
    check("sh_addr", dmem_addr, 64'h100);
    check("sh_stall", stall_out, 0);
    tick();
    check("sh_wb_we", wb_RegWrite_out, 0);
    idle();

    // misaligned LW
    drive(64'h102, 64'd0, 5'd3, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
    dmem_ready = 1'b1;
    @(negedge clk);
    check("mis_req", dmem_req, 0);
    check("mis_stall", stall_out, 0);
    tick();
    check("mis_pulse", misalign_err_out, 1);
    check("mis_wb_we", wb_RegWrite_out, 0);
    idle();
    tick();
    check("mis_pulse_end", misalign_err_out, 0);

    // timeout: IDLE stall + 3 stalling WAIT cycles, then give up
    drive(64'h200, 64'd0, 5'd4, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!stall_out) break;
      n++;
    end
    check("tmo_stall_cycles", n, 4);
    check("tmo_req_drop", dmem_req, 0);
    tick();
    check("tmo_bus_err", bus_err_out, 1);
    check("tmo_wb_we", wb_RegWrite_out, 0);
    idle();
    tick();
    check("tmo_bus_err_end", bus_err_out, 0);

    // reset in WAIT
    drive(64'h300, 64'd0, 5'd6, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("rw_stall", stall_out, 1);
    tick();
    check("rw_req_wait", dmem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rw_req", dmem_req, 0);
    check("rw_stall_rst", stall_out, 0);
    check("rw_wb_data", wb_data_out, 0);
    check("rw_wb_rd", wb_rd_out, 0);
    check("rw_wb_we", wb_RegWrite_out, 0);
    idle();
    dmem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rw_late_req", dmem_req, 0);
    tick();
    check("rw_late_we", wb_RegWrite_out, 0);
    check("rw_late_bus", bus_err_out, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
